// File: rtl/scoreboard_pkg.sv
// Shared definitions for the pipeline hazard scoreboard.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Holds the per-stage entry field widths and the select-width helper used to
// size the forwarding-select outputs (SEL_W = $clog2(STAGES)).
package scoreboard_pkg;

  // Entry layout: {valid, dest[REG_ADDR_W], wbEn, load}.
  localparam int ENTRY_VALID_W = 1;
  localparam int ENTRY_WB_W    = 1;
  localparam int ENTRY_LOAD_W  = 1;
  localparam int ENTRY_FLAG_W  = ENTRY_VALID_W + ENTRY_WB_W + ENTRY_LOAD_W;

  // Forwarding-select width for a given stage count. STAGES is at least 2,
  // so the result is never below 1 bit.
  function automatic int calcSelW(input int stages);
    return (stages < 2) ? 1 : $clog2(stages);
  endfunction

  // Total bits in one scoreboard entry for a given register-address width.
  function automatic int calcEntryW(input int regAddrW);
    return regAddrW + ENTRY_FLAG_W;
  endfunction

  // Select width for the default three-stage (EXE, MEM, WB) pipeline.
  localparam int SEL_W = calcSelW(3);

endpackage

// File: rtl/scoreboard_match.sv
// Per-source hazard lookup: finds the youngest in-flight producer of one source.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result feeds the parent's stall and forward select.
//
// Ports:
//   src, srcUsed          source register address and whether it is read
//   entValid/WbEn/Load    per-stage entry flags, bit k = stage k
//   entDest               per-stage destination, flattened, stage k at [k*W +: W]
//   hit, hitStage, hitLoad  a producer exists, its stage index, and is it a load
module scoreboard_match
  import scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int STAGES     = 3,
  parameter int SEL_W_P    = calcSelW(STAGES)
) (
  input  logic [REG_ADDR_W-1:0]        src,
  input  logic                         srcUsed,
  input  logic [STAGES-1:0]            entValid,
  input  logic [STAGES-1:0]            entWbEn,
  input  logic [STAGES-1:0]            entLoad,
  input  logic [STAGES*REG_ADDR_W-1:0] entDest,
  output logic                         hit,
  output logic [SEL_W_P-1:0]           hitStage,
  output logic                         hitLoad
);

  // r0 is hard-wired zero: it never creates a dependency, even as a load dest.
  logic srcLive;
  assign srcLive = srcUsed && (src != '0);

  // Scan oldest to youngest so the last assignment, the lowest stage index,
  // is the one that sticks: the youngest producer holds the newest value.
  always_comb begin
    hit      = 1'b0;
    hitStage = '0;
    hitLoad  = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (srcLive && entValid[k] && entWbEn[k] &&
          (entDest[k*REG_ADDR_W +: REG_ADDR_W] == src)) begin
        hit      = 1'b1;
        hitStage = SEL_W_P'(k);
        hitLoad  = entLoad[k];
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// In-order pipeline scoreboard: tracks post-decode producers, stalls decode on
// load-use hazards and registers the EXE operand forwarding selects.
// Latency: stall is combinational; ex_fw_sel1/2 and stage_valid update one edge
// after issue. Backpressure: stall holds IF/ID; hold freezes every tracked stage.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   hold                  memory wait, freezes entries and forward selects
//   flush                 taken branch, the decode instruction is not issued
//   id_*                  decode-stage instruction (sources, dest, write/load flags)
//   stall                 hold IF and ID this cycle
//   ex_fw_sel1/2          EXE operand select: 0 = register file, j = stage j result
//   stage_valid           per-stage occupancy, bit 0 = EXE
//   stall_cnt, flush_cnt  saturating event counters, present only when
//                         SCOREBOARD_STATS_EN is defined
module pipe_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  localparam int SEL_W_L   = calcSelW(STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_used,
  input  logic                  id_src2_used,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  output logic                  stall,
  output logic [SEL_W_L-1:0]    ex_fw_sel1,
  output logic [SEL_W_L-1:0]    ex_fw_sel2,
  output logic [STAGES-1:0]     stage_valid
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  wbEn;
    logic                  load;
  } entry_t;

  // entries[0] is EXE; higher indices are older instructions.
  entry_t entries [STAGES];

  logic [STAGES-1:0]            entValid;
  logic [STAGES-1:0]            entWbEn;
  logic [STAGES-1:0]            entLoad;
  logic [STAGES*REG_ADDR_W-1:0] entDest;

  for (genvar k = 0; k < STAGES; k++) begin : g_flat
    assign entValid[k]                          = entries[k].valid;
    assign entWbEn[k]                           = entries[k].wbEn;
    assign entLoad[k]                           = entries[k].load;
    assign entDest[k*REG_ADDR_W +: REG_ADDR_W]  = entries[k].dest;
  end

  assign stage_valid = entValid;

  // ---------------------------------------------------------------------------
  // Per-source producer lookup
  // ---------------------------------------------------------------------------
  logic               hit1;
  logic               hit2;
  logic [SEL_W_L-1:0] hitStage1;
  logic [SEL_W_L-1:0] hitStage2;
  logic               hitLoad1;
  logic               hitLoad2;

  scoreboard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .STAGES     (STAGES),
    .SEL_W_P    (SEL_W_L)
  ) u_match1 (
    .src      (id_src1),
    .srcUsed  (id_src1_used),
    .entValid (entValid),
    .entWbEn  (entWbEn),
    .entLoad  (entLoad),
    .entDest  (entDest),
    .hit      (hit1),
    .hitStage (hitStage1),
    .hitLoad  (hitLoad1)
  );

  scoreboard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .STAGES     (STAGES),
    .SEL_W_P    (SEL_W_L)
  ) u_match2 (
    .src      (id_src2),
    .srcUsed  (id_src2_used),
    .entValid (entValid),
    .entWbEn  (entWbEn),
    .entLoad  (entLoad),
    .entDest  (entDest),
    .hit      (hit2),
    .hitStage (hitStage2),
    .hitLoad  (hitLoad2)
  );

  // A load in stage k has its data available to EXE from stage k+1 onward in
  // forwarding terms; if that is still short of LOAD_STAGE the consumer waits.
  function automatic logic loadTooYoung(input logic h, input logic isLoad,
                                        input logic [SEL_W_L-1:0] stg);
    return h && isLoad && ((int'(stg) + 1) < LOAD_STAGE);
  endfunction

  // The producer advances one stage on the issue edge, so the select names
  // k+1. A producer already in the last stage has written the register file
  // before decode reads it, so no forward is needed.
  function automatic logic [SEL_W_L-1:0] fwdSel(input logic h,
                                                input logic [SEL_W_L-1:0] stg);
    if (h && ((int'(stg) + 1) <= (STAGES - 1)))
      return SEL_W_L'(int'(stg) + 1);
    return '0;
  endfunction

  logic hazardStall;
  logic issue;

  assign hazardStall = loadTooYoung(hit1, hitLoad1, hitStage1) |
                       loadTooYoung(hit2, hitLoad2, hitStage2);
  assign stall       = hold | hazardStall;
  assign issue       = id_valid & ~stall & ~flush & ~hold;

  entry_t newEntry;
  always_comb begin
    newEntry       = '0;
    newEntry.valid = 1'b1;
    newEntry.dest  = id_dest;
    newEntry.wbEn  = id_wb_en;
    newEntry.load  = id_mem_r_en;
  end

  // ---------------------------------------------------------------------------
  // Stage shift register and forwarding selects
  // ---------------------------------------------------------------------------
  // Reset wins over hold and flush; hold wins over everything else, which is
  // why a flush arriving during hold is simply lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        entries[k] <= '0;
      end
      ex_fw_sel1 <= '0;
      ex_fw_sel2 <= '0;
    end else if (!hold) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        entries[k] <= entries[k-1];
      end
      entries[0] <= issue ? newEntry : entry_t'('0);
      ex_fw_sel1 <= issue ? fwdSel(hit1, hitStage1) : '0;
      ex_fw_sel2 <= issue ? fwdSel(hit2, hitStage2) : '0;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating event counters. stall includes hold, so masking with ~hold
  // leaves only genuine hazard stalls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !hold && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && !hold && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Self-checking bench for pipe_scoreboard (STAGES=3, LOAD_STAGE=2).
// Directed vector table, hand sequences, then random stimulus vs a queue model.
// Counter checks are compiled in when SCOREBOARD_STATS_EN is defined.
module tb_pipe_scoreboard;

  localparam int AW = 5;
  localparam int ST = 3;
  localparam int LS = 2;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic          flush = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_src1 = '0;
  logic [AW-1:0] id_src2 = '0;
  logic          id_src1_used = 1'b0;
  logic          id_src2_used = 1'b0;
  logic [AW-1:0] id_dest = '0;
  logic          id_wb_en = 1'b0;
  logic          id_mem_r_en = 1'b0;
  logic          stall;
  logic [SW-1:0] ex_fw_sel1;
  logic [SW-1:0] ex_fw_sel2;
  logic [ST-1:0] stage_valid;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_scoreboard #(
    .REG_ADDR_W (AW),
    .STAGES     (ST),
    .LOAD_STAGE (LS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_mem_r_en  (id_mem_r_en),
    .stall        (stall),
    .ex_fw_sel1   (ex_fw_sel1),
    .ex_fw_sel2   (ex_fw_sel2),
    .stage_valid  (stage_valid)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // One cycle of stimulus plus the expected outcome: eStall is sampled before
  // the edge, the selects and occupancy after it.
  typedef struct {
    logic          rst, hold, flush, v;
    logic [AW-1:0] s1, s2, d;
    logic          u1, u2, wb, ld;
    logic          eStall;
    logic [SW-1:0] eSel1, eSel2;
    logic [ST-1:0] eSv;
  } vec_t;

  function automatic vec_t mkv(input int r, input int h, input int f, input int v,
                               input int s1, input int u1, input int s2, input int u2,
                               input int d, input int wb, input int ld,
                               input int es, input int e1, input int e2, input int esv);
    vec_t t;
    t.rst = r[0];  t.hold = h[0];  t.flush = f[0];  t.v = v[0];
    t.s1 = AW'(s1); t.u1 = u1[0]; t.s2 = AW'(s2); t.u2 = u2[0];
    t.d = AW'(d);  t.wb = wb[0];  t.ld = ld[0];
    t.eStall = es[0]; t.eSel1 = SW'(e1); t.eSel2 = SW'(e2); t.eSv = ST'(esv);
    return t;
  endfunction

  task automatic drive(input vec_t t, output logic aStall,
                       output logic [SW-1:0] a1, output logic [SW-1:0] a2,
                       output logic [ST-1:0] aSv);
    @(negedge clk);
    rst = t.rst; hold = t.hold; flush = t.flush; id_valid = t.v;
    id_src1 = t.s1; id_src1_used = t.u1; id_src2 = t.s2; id_src2_used = t.u2;
    id_dest = t.d; id_wb_en = t.wb; id_mem_r_en = t.ld;
    #1 aStall = stall;
    @(posedge clk);
    #1;
    a1 = ex_fw_sel1; a2 = ex_fw_sel2; aSv = stage_valid;
  endtask

  // Behavioural model: a queue of in-flight instructions, youngest at the front.
  typedef struct {
    bit valid;
    int dest;
    bit wb;
    bit ld;
  } ins_t;

  ins_t pipe[$];
  int   mSel1, mSel2;
  int unsigned mStallCnt, mFlushCnt;

  function automatic ins_t bubble();
    ins_t b;
    b.valid = 0; b.dest = 0; b.wb = 0; b.ld = 0;
    return b;
  endfunction

  task automatic modelReset();
    pipe.delete();
    for (int k = 0; k < ST; k++) pipe.push_back(bubble());
    mSel1 = 0; mSel2 = 0; mStallCnt = 0; mFlushCnt = 0;
  endtask

  // Position of the youngest in-flight writer of src, or -1.
  function automatic int findProducer(input int src, input bit used);
    if (!used || src == 0) return -1;
    foreach (pipe[k])
      if (pipe[k].valid && pipe[k].wb && pipe[k].dest == src) return k;
    return -1;
  endfunction

  vec_t          tbl[$];
  vec_t          t;
  logic          aStall;
  logic [SW-1:0] a1, a2;
  logic [ST-1:0] aSv;

  initial begin
    // ---------------- directed table ----------------
    tbl.push_back(mkv(1,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b000)); // reset state
    // ADD r3, then consumer of r3: forward from stage 1
    tbl.push_back(mkv(0,0,0,1, 0,0,0,0, 3,1,0,  0,0,0,3'b001));
    tbl.push_back(mkv(0,0,0,1, 3,1,0,0, 7,1,0,  0,1,0,3'b011));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b110));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b100));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b000));
    // LW r4, consumer on src2: one stall, then forward from stage 2
    tbl.push_back(mkv(0,0,0,1, 0,0,0,0, 4,1,1,  0,0,0,3'b001));
    tbl.push_back(mkv(0,0,0,1, 0,0,4,1, 8,1,0,  1,0,0,3'b010));
    tbl.push_back(mkv(0,0,0,1, 0,0,4,1, 8,1,0,  0,0,2,3'b101));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b010));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b100));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b000));
    // ADD r5, ADD r5, consumer r5: youngest wins
    tbl.push_back(mkv(0,0,0,1, 0,0,0,0, 5,1,0,  0,0,0,3'b001));
    tbl.push_back(mkv(0,0,0,1, 0,0,0,0, 5,1,0,  0,0,0,3'b011));
    tbl.push_back(mkv(0,0,0,1, 5,1,0,0, 9,1,0,  0,1,0,3'b111));
    // load to r0, then both sources r0: never a hazard
    tbl.push_back(mkv(0,0,0,1, 0,0,0,0, 0,1,1,  0,0,0,3'b111));
    tbl.push_back(mkv(0,0,0,1, 0,1,0,1, 1,1,0,  0,0,0,3'b111));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b110));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b100));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b000));
    // r6 producer reaches the last stage: register file supplies it
    tbl.push_back(mkv(0,0,0,1, 0,0,0,0, 6,1,0,  0,0,0,3'b001));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b010));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b100));
    tbl.push_back(mkv(0,0,0,1, 6,1,0,0, 10,1,0, 0,0,0,3'b001));
    // unused source against a matching load: no stall
    tbl.push_back(mkv(0,0,0,1, 0,0,0,0, 11,1,1, 0,0,0,3'b011));
    tbl.push_back(mkv(0,0,0,1, 11,0,0,0, 12,1,0, 0,0,0,3'b111));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b110));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b100));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b000));
    // flush with a valid decode instruction: bubble
    tbl.push_back(mkv(0,0,1,1, 0,0,0,0, 13,1,0, 0,0,0,3'b000));
    // hold for 3 cycles (last with flush): everything frozen
    tbl.push_back(mkv(0,0,0,1, 0,0,0,0, 14,1,0, 0,0,0,3'b001));
    tbl.push_back(mkv(0,0,0,1, 14,1,0,0, 15,1,0, 0,1,0,3'b011));
    tbl.push_back(mkv(0,1,0,1, 15,1,0,0, 16,1,0, 1,1,0,3'b011));
    tbl.push_back(mkv(0,1,0,1, 15,1,0,0, 16,1,0, 1,1,0,3'b011));
    tbl.push_back(mkv(0,1,1,1, 15,1,0,0, 16,1,0, 1,1,0,3'b011));
    tbl.push_back(mkv(0,0,0,1, 15,1,0,0, 16,1,0, 0,1,0,3'b111));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b110));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b100));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b000));
    // reset in the middle of a load-use stall
    tbl.push_back(mkv(0,0,0,1, 0,0,0,0, 17,1,1, 0,0,0,3'b001));
    tbl.push_back(mkv(1,0,0,1, 17,1,0,0, 18,1,0, 1,0,0,3'b000));
    tbl.push_back(mkv(0,0,0,1, 17,1,0,0, 18,1,0, 0,0,0,3'b001));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b010));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b100));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,3'b000));

    // Bring the DUT out of its unknown power-up state first.
    repeat (2) drive(tbl[0], aStall, a1, a2, aSv);

    foreach (tbl[i]) begin
      drive(tbl[i], aStall, a1, a2, aSv);
      chk("tbl_stall", i, 32'(aStall), 32'(tbl[i].eStall));
      chk("tbl_sel1",  i, 32'(a1),     32'(tbl[i].eSel1));
      chk("tbl_sel2",  i, 32'(a2),     32'(tbl[i].eSel2));
      chk("tbl_valid", i, 32'(aSv),    32'(tbl[i].eSv));
    end

    // ---------------- load-use stall lasts exactly one cycle ----------------
    begin
      int stallCycles = 0;
      bit done = 0;
      drive(mkv(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0), aStall, a1, a2, aSv);
      drive(mkv(0,0,0,1, 0,0,0,0, 20,1,1, 0,0,0,0), aStall, a1, a2, aSv);
      for (int n = 0; n < 6 && !done; n++) begin
        drive(mkv(0,0,0,1, 0,0,20,1, 21,1,0, 0,0,0,0), aStall, a1, a2, aSv);
        if (aStall) stallCycles++;
        else done = 1;
      end
      chk("luse_done", 0, 32'(done), 32'd1);
      chk("luse_stall_cycles", 0, 32'(stallCycles), 32'd1);
      chk("luse_sel2", 0, 32'(a2), 32'd2);
      // flush while stalled still bubbles stage 0
      drive(mkv(0,0,0,1, 0,0,0,0, 22,1,1, 0,0,0,0), aStall, a1, a2, aSv);
      drive(mkv(0,0,1,1, 22,1,0,0, 23,1,0, 0,0,0,0), aStall, a1, a2, aSv);
      chk("flush_stall_pre", 0, 32'(aStall), 32'd1);
      chk("flush_stall_v0", 0, 32'(aSv[0]), 32'd0);
    end

`ifdef SCOREBOARD_STATS_EN
    // ---------------- event counters ----------------
    drive(mkv(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0), aStall, a1, a2, aSv);
    chk("cnt_rst_stall", 0, stall_cnt, 32'd0);
    chk("cnt_rst_flush", 0, flush_cnt, 32'd0);
    drive(mkv(0,0,0,1, 0,0,0,0, 4,1,1, 0,0,0,0), aStall, a1, a2, aSv);
    drive(mkv(0,0,0,1, 0,0,4,1, 8,1,0, 0,0,0,0), aStall, a1, a2, aSv);
    chk("cnt_stall_1", 0, stall_cnt, 32'd1);
    drive(mkv(0,0,0,1, 0,0,4,1, 8,1,0, 0,0,0,0), aStall, a1, a2, aSv);
    chk("cnt_stall_1b", 0, stall_cnt, 32'd1);
    drive(mkv(0,0,1,1, 0,0,0,0, 9,1,0, 0,0,0,0), aStall, a1, a2, aSv);
    chk("cnt_flush_1", 0, flush_cnt, 32'd1);
    drive(mkv(0,1,1,1, 0,0,0,0, 9,1,0, 0,0,0,0), aStall, a1, a2, aSv);
    chk("cnt_flush_hold", 0, flush_cnt, 32'd1);
    drive(mkv(0,0,0,1, 0,0,0,0, 5,1,1, 0,0,0,0), aStall, a1, a2, aSv);
    drive(mkv(0,1,0,1, 5,1,0,0, 6,1,0, 0,0,0,0), aStall, a1, a2, aSv);
    chk("cnt_stall_hold", 0, stall_cnt, 32'd1);
    drive(mkv(0,0,0,1, 5,1,0,0, 6,1,0, 0,0,0,0), aStall, a1, a2, aSv);
    chk("cnt_stall_2", 0, stall_cnt, 32'd2);
`endif

    // ---------------- random stimulus vs model ----------------
    drive(mkv(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0), aStall, a1, a2, aSv);
    modelReset();
    for (int i = 0; i < 600; i++) begin
      int  p1, p2;
      bit  expStall, iss;
      logic [ST-1:0] expSv;
      t = mkv(($urandom_range(39, 0) == 0) ? 1 : 0,
              ($urandom_range(7, 0) == 0) ? 1 : 0,
              ($urandom_range(7, 0) == 0) ? 1 : 0,
              ($urandom_range(3, 0) != 0) ? 1 : 0,
              $urandom_range(7, 0), $urandom_range(1, 0),
              $urandom_range(7, 0), $urandom_range(1, 0),
              $urandom_range(7, 0), ($urandom_range(3, 0) != 0) ? 1 : 0,
              ($urandom_range(2, 0) == 0) ? 1 : 0,
              0, 0, 0, 0);
      p1 = findProducer(int'(t.s1), t.u1);
      p2 = findProducer(int'(t.s2), t.u2);
      expStall = t.hold || (p1 >= 0 && pipe[p1].ld && p1 + 1 < LS) ||
                 (p2 >= 0 && pipe[p2].ld && p2 + 1 < LS);
      iss = t.v && !expStall && !t.flush && !t.hold;

      drive(t, aStall, a1, a2, aSv);
      chk("rnd_stall", i, 32'(aStall), 32'(expStall));

      if (t.rst) begin
        modelReset();
      end else if (!t.hold) begin
        ins_t n;
        if (expStall) mStallCnt++;
        if (t.flush) mFlushCnt++;
        n = bubble();
        if (iss) begin
          n.valid = 1; n.dest = int'(t.d); n.wb = t.wb; n.ld = t.ld;
        end
        pipe.push_front(n);
        void'(pipe.pop_back());
        mSel1 = (iss && p1 >= 0 && p1 + 1 <= ST - 1) ? p1 + 1 : 0;
        mSel2 = (iss && p2 >= 0 && p2 + 1 <= ST - 1) ? p2 + 1 : 0;
      end

      for (int k = 0; k < ST; k++) expSv[k] = pipe[k].valid;
      chk("rnd_sel1",  i, 32'(a1),  32'(mSel1));
      chk("rnd_sel2",  i, 32'(a2),  32'(mSel2));
      chk("rnd_valid", i, 32'(aSv), 32'(expSv));
`ifdef SCOREBOARD_STATS_EN
      chk("rnd_stall_cnt", i, stall_cnt, mStallCnt);
      chk("rnd_flush_cnt", i, flush_cnt, mFlushCnt);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 Parameter REG_ADDR_W, default 5, SHALL set the register-address width.
REQ-002 Parameter STAGES, default 3 (EXE, MEM, WB), SHALL set the number of tracked post-decode stages; legal values are 2..8.
REQ-003 Parameter LOAD_STAGE, default 2, SHALL set the lowest stage index at which a load result may be forwarded.
REQ-004 The block SHALL have ports:
 - clk  in  1  clock, rising edge.
 - rst  in  1  reset, synchronous, active-high.
 - hold  in  1  freeze all tracking (memory wait).
 - flush  in  1  branch taken; the decode-stage instruction is not issued.
 - id_valid  in  1  decode stage holds an instruction.
 - id_src1, id_src2  in  REG_ADDR_W  source registers.
 - id_src1_used, id_src2_used  in  1  each source is actually read.
 - id_dest  in  REG_ADDR_W  destination register.
 - id_wb_en  in  1  instruction writes a register.
 - id_mem_r_en  in  1  instruction is a load.
 - stall  out  1  hold the IF and ID stages this cycle.
 - ex_fw_sel1, ex_fw_sel2  out  $clog2(STAGES)  EXE operand select: 0 = decode-read value; j = result of instruction in stage j.
 - stage_valid  out  STAGES  per-stage occupancy.

Function
REQ-005 The block SHALL keep STAGES entries {valid, dest, wb_en, load}; stage 0 = EXE.
REQ-006 Issue SHALL be id_valid & ~stall & ~flush & ~hold.
REQ-007 On each edge with hold=0, entry k SHALL move to k+1, the last entry SHALL retire, and stage 0 SHALL load the issued instruction, or an invalid bubble if there is no issue.
REQ-008 A source SHALL match stage k when: used, nonzero, equal to dest, valid, and wb_en.
REQ-009 Where several stages match, the lowest index (youngest) SHALL win.
REQ-010 stall SHALL be combinational: hold, or any winning match that is a load with k+1 < LOAD_STAGE.
REQ-011 On issue, ex_fw_selN SHALL register k+1 for a winning match with k+1 <= STAGES-1; otherwise it SHALL register 0.
REQ-012 A match in stage STAGES-1 SHALL give 0, because the register file is write-before-read.
REQ-013 On a non-issue edge with hold=0, ex_fw_selN SHALL clear to 0.
REQ-014 While hold=1, entries and ex_fw_selN SHALL be frozen, and hold SHALL take priority over flush.
REQ-015 A flush edge with hold=0 SHALL insert a bubble into stage 0, regardless of stall.
REQ-016 Register 0 SHALL never match, including when it is the dest of a load.

Reset
REQ-017 When rst=1 at an edge, all valid bits, ex_fw_sel1/2 and the counters SHALL clear to 0.
REQ-018 After reset, stall SHALL be 0 unless hold=1.
REQ-019 rst SHALL override hold and flush.
REQ-020 Reset mid-stall SHALL discard all in-flight hazards.

Configuration
REQ-021 With SCOREBOARD_STATS_EN defined, outputs stall_cnt[31:0] and flush_cnt[31:0] SHALL exist.
REQ-022 stall_cnt SHALL count edges with stall=1 and hold=0; flush_cnt SHALL count edges with flush=1 and hold=0.
REQ-023 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-024 Without SCOREBOARD_STATS_EN, these ports and their logic SHALL be absent.

Structure
REQ-025 Package scoreboard_pkg SHALL hold the entry field widths and the SEL_W=$clog2(STAGES) function/constant.
REQ-026 Sub-module scoreboard_match SHALL hold the per-source priority match (youngest-wins encoder plus load flag) and be instantiated twice.

Verification
REQ-027 Bench defaults are STAGES=3, LOAD_STAGE=2. The bench SHALL cover:
 - ADD r3 issued, then src1=r3 -> stall=0; ex_fw_sel1=1 on the following cycle.
 - LW r4 issued, then src2=r4 -> stall=1 for exactly 1 cycle; the consumer then issues with ex_fw_sel2=2.
 - ADD r5 followed by ADD r5, then src1=r5 -> youngest wins, ex_fw_sel1=1; src1=r0 with dest r0 pending -> sel 0, no stall.
 - Producer r6 in stage 2 at decode -> ex_fw_sel=0; id_src1_used=0 against a matching load -> no stall.
 - flush=1 with id_valid=1 -> stage_valid[0]=0 next cycle; hold=1 for 3 cycles -> stage_valid unchanged, stall=1; flush during hold -> ignored.
 - rst asserted mid load-stall -> next cycle stage_valid=0, stall=0; with SCOREBOARD_STATS_EN, the counters read 0, then increment 1 per stall edge.
